uart_rx_fifo_mapper: RTL and testbench
======================================

Name: uart_rx_fifo_mapper

Overview:
- Memory-mapped receive buffer between uart_input and the 6502 data bus, in the uart_enabled decode window (address_bus[14]).
- Queues bytes arriving from uart_input so that fast typing is not lost while the CPU services the IRQ.
- Exposes a data register (pop on read), a status/control register, and a level-style IRQ.
- Replaces the single-byte hold of uart_mapper.

Parameters:
- DEPTH, 16, number of byte entries; power of two, 2..16.
- AW, 4, pointer width; equals log2(DEPTH).

Ports:
- clk  in  1  system clock (clk_sys)
- rst_n  in  1  asynchronous active-low reset
- uart_byte  in  8  received byte from uart_input
- uart_byte_ready  in  1  one-cycle pulse; uart_byte valid in that cycle
- cs  in  1  chip select (address_bus[14])
- addr  in  1  register select (address_bus[0]): 0 = DATA, 1 = STATUS/CTRL
- we  in  1  CPU write enable
- wdata  in  8  CPU write data (data_out)
- rdata  out  8  registered read data for the data-bus mux
- irq  out  1  registered IRQ to cpu6502, active high

Behaviour:
- Storage: DEPTH x 8 register array; head/tail pointers of AW bits wrap modulo DEPTH; count of AW+1 bits, 0..DEPTH.
- Access detect: an access is the first cycle of any run of consecutive cycles with identical {cs=1, addr, we}.
  - Only that first cycle acts (pop, control write).
  - Holding the same access for further cycles has no further effect.
  - cs must drop, or addr/we must change, to start a new access.
- Push: on uart_byte_ready with count<DEPTH, write mem[tail]; tail+1; count+1.
- Push when full: byte dropped; overflow flag <= 1; no other state changes.
- DATA read (access, addr=0, we=0):
  - Non-empty: rdata <= mem[head] at the clock edge ending the access cycle; head+1; count-1.
  - Empty: rdata <= 8'h00; no pointer change.
- STATUS read (access, addr=1, we=0): rdata <= {irq_en, overflow, full, count[4:0]}.
  - full = (count==DEPTH).
  - count is zero-extended to 5 bits.
- rdata latency: exactly 1 clk after the access cycle. rdata holds its last value when no read access occurs.
- CTRL write (access, addr=1, we=1), bits act independently:
  - wdata[0]=1: clear overflow.
  - wdata[1]=1: flush; head=tail=0, count=0.
  - wdata[7]: new irq_en value.
- DATA write (addr=0, we=1): ignored.
- Simultaneous push and pop in one cycle:
  - Both occur; count unchanged.
  - Allowed when full, so no overflow is set.
  - When empty, the pop returns 8'h00 and the push still stores the byte (count 0->1).
- Simultaneous push and flush: flush wins; the incoming byte is discarded; overflow unaffected unless wdata[0]=1.
- Simultaneous overflow-set and CTRL clear: set wins (overflow=1).
- irq: registered; next-state is irq_en & (count_next != 0).
  - Level behaviour: stays high until the FIFO is drained or irq_en=0.
  - No separate acknowledge.
- Reset (async assert, synchronous-release use by top): head=tail=0, count=0, overflow=0, irq_en=1, rdata=8'h00, irq=0, access-detect history cleared.
  - Reset mid-operation drops all queued bytes.
  - Memory contents need not be cleared.
- No combinational path from cs/addr/we to rdata or irq.

Test Plan:
- Reset, then pulse uart_byte_ready with 8'h41, 8'h42, 8'h43 -> irq=1 one clk after first push; STATUS read returns 8'h83; three DATA reads return 41, 42, 43; irq falls 1 clk after third pop; a fourth DATA read returns 8'h00.
- Push 17 bytes 8'h00..8'h10 with DEPTH=16 -> STATUS = 8'hF0 (irq_en, overflow, full, count=16 encoded as 5'b10000); reads return 00..0F; 8'h10 lost; CTRL write 8'h81 -> STATUS = 8'h80.
- Full FIFO, push 8'hAA in the same cycle as a DATA read access -> read returns oldest byte; count stays 16; overflow stays 0; last entry read is 8'hAA.
- Hold cs=1, addr=0, we=0 for 5 cycles with 3 bytes queued -> exactly one pop (count 3->2); drop cs for 1 cycle and reassert -> second pop.
- CTRL write 8'h02 in the same cycle as uart_byte_ready=1 (byte 8'h55) -> count=0; irq=0; next DATA read returns 8'h00.
- CTRL write 8'h00 (irq_en=0), push 2 bytes -> irq stays 0; CTRL write 8'h80 -> irq=1 next clk. Assert rst_n=0 mid-stream -> irq, rdata, count all 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/uart_rx_fifo_mapper.sv
// Memory-mapped UART receive FIFO for the 6502 bus: DATA (pop on read) and STATUS/CTRL registers, level IRQ.
// Read data and IRQ are registered; only the first cycle of a held bus access has any effect.
module uart_rx_fifo_mapper #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] uart_byte,
   input  logic       uart_byte_ready,
   input  logic       cs,
   input  logic       addr,
   input  logic       we,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       irq
);

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] head_q, head_d;
   logic [AW-1:0] tail_q, tail_d;
   logic [AW:0]   count_q, count_d;
   logic          overflow_q, overflow_d;
   logic          irq_en_q, irq_en_d;
   logic [7:0]    rdata_q, rdata_d;
   logic          irq_q, irq_d;
   logic          prev_cs_q, prev_cs_d;
   logic          prev_addr_q, prev_addr_d;
   logic          prev_we_q, prev_we_d;

   logic          access;
   logic          data_rd, stat_rd, ctrl_wr, flush;
   logic          empty, full;
   logic          do_pop, push_ok, ovf_set;
   logic [4:0]    count5;

   always_comb begin
      // A new access starts only when {cs, addr, we} differs from the previous cycle
      access  = cs && !(prev_cs_q && (prev_addr_q == addr) && (prev_we_q == we));
      data_rd = access && !addr && !we;
      stat_rd = access && addr && !we;
      ctrl_wr = access && addr && we;
      flush   = ctrl_wr && wdata[1];

      empty   = (count_q == '0);
      full    = (count_q == DEPTH_C);
      count5  = 5'(count_q);

      do_pop  = data_rd && !empty;
      push_ok = uart_byte_ready && !flush && (!full || do_pop);
      ovf_set = uart_byte_ready && !flush && full && !do_pop;

      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (do_pop) head_d = head_q + 1'b1;
         if (push_ok) tail_d = tail_q + 1'b1;
         case ({push_ok, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end

      // Set has priority over a same-cycle clear
      overflow_d = overflow_q;
      if (ctrl_wr && wdata[0]) overflow_d = 1'b0;
      if (ovf_set) overflow_d = 1'b1;

      irq_en_d = ctrl_wr ? wdata[7] : irq_en_q;

      rdata_d = rdata_q;
      if (data_rd) rdata_d = empty ? 8'h00 : mem_q[head_q];
      if (stat_rd) rdata_d = {irq_en_q, overflow_q, full, count5};

      irq_d = irq_en_d && (count_d != '0);

      prev_cs_d   = cs;
      prev_addr_d = addr;
      prev_we_d   = we;
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[tail_q] <= uart_byte;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         irq_en_q    <= 1'b1;
         rdata_q     <= 8'h00;
         irq_q       <= 1'b0;
         prev_cs_q   <= 1'b0;
         prev_addr_q <= 1'b0;
         prev_we_q   <= 1'b0;
      end else begin
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         irq_en_q    <= irq_en_d;
         rdata_q     <= rdata_d;
         irq_q       <= irq_d;
         prev_cs_q   <= prev_cs_d;
         prev_addr_q <= prev_addr_d;
         prev_we_q   <= prev_we_d;
      end
   end

   assign rdata = rdata_q;
   assign irq   = irq_q;

endmodule

// File: tb/tb_uart_rx_fifo_mapper.sv
// Scoreboard bench for uart_rx_fifo_mapper: queued bytes, status, overflow, flush, held accesses, IRQ, reset.
module tb_uart_rx_fifo_mapper;

   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] uart_byte = 8'h00;
   logic       uart_byte_ready = 1'b0;
   logic       cs = 1'b0;
   logic       addr = 1'b0;
   logic       we = 1'b0;
   logic [7:0] wdata = 8'h00;
   logic [7:0] rdata;
   logic       irq;

   int         n_tests = 0;
   int         n_fail = 0;

   logic [7:0] sb[$];
   logic       m_ovf = 1'b0;
   logic       m_irq_en = 1'b1;

   uart_rx_fifo_mapper #(.DEPTH(DEPTH), .AW(4)) dut (
      .clk(clk), .rst_n(rst_n), .uart_byte(uart_byte), .uart_byte_ready(uart_byte_ready),
      .cs(cs), .addr(addr), .we(we), .wdata(wdata), .rdata(rdata), .irq(irq)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h expected %02h", tag, act, exp);
      end
   endtask

   function automatic logic [7:0] status_model();
      return {m_irq_en, m_ovf, sb.size() == DEPTH, 5'(sb.size())};
   endfunction

   function automatic logic irq_model();
      return m_irq_en && (sb.size() != 0);
   endfunction

   task automatic model_push(input logic [7:0] b);
      if (sb.size() < DEPTH) sb.push_back(b);
      else m_ovf = 1'b1;
   endtask

   task automatic push_byte(input logic [7:0] b);
      uart_byte = b;
      uart_byte_ready = 1'b1;
      model_push(b);
      @(posedge clk); #1;
      uart_byte_ready = 1'b0;
      chk("irq_push", irq, irq_model());
   endtask

   // One bus access preceded by an idle cycle so every call is a fresh access
   task automatic cpu_access(input logic a, input logic w, input logic [7:0] d,
                             input logic psh, input logic [7:0] pb);
      logic [7:0] exp;
      exp = 8'h00;
      cs = 1'b0;
      @(posedge clk); #1;
      cs = 1'b1; addr = a; we = w; wdata = d;
      uart_byte = pb; uart_byte_ready = psh;
      if (a && !w) exp = status_model();
      if (!a && !w) exp = (sb.size() != 0) ? sb.pop_front() : 8'h00;
      if (a && w) begin
         if (d[0]) m_ovf = 1'b0;
         if (d[1]) sb.delete();
         m_irq_en = d[7];
      end
      if (psh && !(a && w && d[1])) model_push(pb);
      @(posedge clk); #1;
      cs = 1'b0; uart_byte_ready = 1'b0;
      if (!w) chk(a ? "status" : "data", rdata, exp);
      chk("irq_acc", irq, irq_model());
   endtask

   task automatic rd_data();
      cpu_access(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
   endtask

   task automatic rd_status();
      cpu_access(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
   endtask

   task automatic wr_ctrl(input logic [7:0] d);
      cpu_access(1'b1, 1'b1, d, 1'b0, 8'h00);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("reset_rdata", rdata, 8'h00);
      chk("reset_irq", irq, 1'b0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      rd_status();
      chk("reset_status", rdata, 8'h80);

      // Basic ordering and IRQ level
      push_byte(8'h41);
      chk("irq_first_push", irq, 1'b1);
      push_byte(8'h42);
      push_byte(8'h43);
      rd_status();
      chk("status_83", rdata, 8'h83);
      rd_data();
      rd_data();
      chk("irq_before_last", irq, 1'b1);
      rd_data();
      chk("irq_after_drain", irq, 1'b0);
      rd_data();
      chk("empty_read", rdata, 8'h00);

      // Overflow on the 17th byte
      for (int i = 0; i <= DEPTH; i++) push_byte(8'(i));
      rd_status();
      chk("status_f0", rdata, 8'hF0);
      for (int i = 0; i < DEPTH; i++) rd_data();
      wr_ctrl(8'h81);
      rd_status();
      chk("status_80", rdata, 8'h80);

      // Push and pop together while full
      for (int i = 0; i < DEPTH; i++) push_byte(8'h20 + 8'(i));
      cpu_access(1'b0, 1'b0, 8'h00, 1'b1, 8'hAA);
      chk("full_pushpop", rdata, 8'h20);
      rd_status();
      chk("status_b0", rdata, 8'hB0);
      for (int i = 0; i < DEPTH; i++) rd_data();
      chk("last_aa", rdata, 8'hAA);

      // Overflow set beats a same-cycle clear; DATA writes are ignored
      for (int i = 0; i < DEPTH; i++) push_byte(8'h90 + 8'(i));
      cpu_access(1'b1, 1'b1, 8'h81, 1'b1, 8'hBB);
      cpu_access(1'b0, 1'b1, 8'h5A, 1'b0, 8'h00);
      rd_status();
      chk("ovf_set_wins", rdata, 8'hF0);
      wr_ctrl(8'h83);
      rd_status();

      // Held access pops exactly once
      push_byte(8'h61);
      push_byte(8'h62);
      push_byte(8'h63);
      cs = 1'b1; addr = 1'b0; we = 1'b0;
      void'(sb.pop_front());
      @(posedge clk); #1;
      chk("hold_first", rdata, 8'h61);
      repeat (4) @(posedge clk);
      #1;
      chk("hold_no_repop", rdata, 8'h61);
      cs = 1'b0;
      rd_status();
      chk("hold_count2", rdata, 8'h82);
      rd_data();
      chk("hold_second", rdata, 8'h62);
      rd_data();

      // Flush wins over a same-cycle push
      push_byte(8'h11);
      push_byte(8'h12);
      cpu_access(1'b1, 1'b1, 8'h82, 1'b1, 8'h55);
      chk("flush_irq", irq, 1'b0);
      rd_status();
      chk("flush_status", rdata, 8'h80);
      rd_data();
      chk("flush_read", rdata, 8'h00);

      // IRQ enable gating
      wr_ctrl(8'h00);
      push_byte(8'h71);
      push_byte(8'h72);
      chk("irq_disabled", irq, 1'b0);
      wr_ctrl(8'h80);
      chk("irq_enabled", irq, 1'b1);
      rd_data();
      chk("pre_reset_rdata", rdata, 8'h71);

      // Asynchronous reset mid-stream
      push_byte(8'h73);
      rst_n = 1'b0;
      #1;
      chk("async_irq", irq, 1'b0);
      chk("async_rdata", rdata, 8'h00);
      sb.delete();
      m_ovf = 1'b0;
      m_irq_en = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      rd_status();
      chk("post_reset_status", rdata, 8'h80);
      rd_data();
      chk("post_reset_read", rdata, 8'h00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
